// File: rtl/dm_arbiter.sv
// Two-port data-memory arbiter: serialises CPU and EXT accesses onto one RAM port
// through an IDLE -> ACCESS -> DONE handshake, with round-robin and bounded EXT lock.
module dm_arbiter #(
    parameter int ADDR_WIDTH = 11,
    parameter int DATA_WIDTH = 11,
    parameter int MAX_LOCK   = 4
) (
    input  logic                  CLK_i,
    input  logic                  RST_i,
    input  logic                  CPU_REQ_i,
    input  logic                  CPU_WR_i,
    input  logic [ADDR_WIDTH-1:0] CPU_ADDR_i,
    input  logic [DATA_WIDTH-1:0] CPU_WDATA_i,
    output logic                  CPU_ACK_o,
    output logic [DATA_WIDTH-1:0] CPU_RDATA_o,
    input  logic                  EXT_REQ_i,
    input  logic                  EXT_WR_i,
    input  logic [ADDR_WIDTH-1:0] EXT_ADDR_i,
    input  logic [DATA_WIDTH-1:0] EXT_WDATA_i,
    input  logic                  EXT_LOCK_i,
    output logic                  EXT_ACK_o,
    output logic [DATA_WIDTH-1:0] EXT_RDATA_o,
    output logic                  WR_o,
    output logic [ADDR_WIDTH-1:0] ADDR_dm_o,
    output logic [DATA_WIDTH-1:0] IN_DATA_o,
    input  logic [DATA_WIDTH-1:0] OUT_DATA_i,
    output logic [1:0]            GNT_o
);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        DONE
    } state_t;

    localparam logic [3:0] LOCK_MAX = 4'(MAX_LOCK);

    state_t     state;
    logic       ptr_ext;
    logic [3:0] lock_cnt;
    logic       grant_ext;

    // EXT wins alone, or on contention when the pointer names it and its lock budget remains
    always_comb begin
        grant_ext = EXT_REQ_i && (!CPU_REQ_i || (ptr_ext && (lock_cnt < LOCK_MAX)));
    end

    always_ff @(posedge CLK_i) begin
        if (!RST_i) begin
            state       <= IDLE;
            WR_o        <= 1'b0;
            ADDR_dm_o   <= '0;
            IN_DATA_o   <= '0;
            GNT_o       <= 2'b00;
            CPU_ACK_o   <= 1'b0;
            EXT_ACK_o   <= 1'b0;
            CPU_RDATA_o <= '0;
            EXT_RDATA_o <= '0;
            ptr_ext     <= 1'b0;
            lock_cnt    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (CPU_REQ_i || EXT_REQ_i) begin
                        state <= ACCESS;
                        if (grant_ext) begin
                            GNT_o     <= 2'b10;
                            WR_o      <= EXT_WR_i;
                            ADDR_dm_o <= EXT_ADDR_i;
                            IN_DATA_o <= EXT_WDATA_i;
                            if (EXT_LOCK_i) begin
                                ptr_ext <= 1'b1;
                                if (lock_cnt < LOCK_MAX) begin
                                    lock_cnt <= lock_cnt + 4'd1;
                                end
                            end else begin
                                ptr_ext  <= 1'b0;
                                lock_cnt <= '0;
                            end
                        end else begin
                            GNT_o     <= 2'b01;
                            WR_o      <= CPU_WR_i;
                            ADDR_dm_o <= CPU_ADDR_i;
                            IN_DATA_o <= CPU_WDATA_i;
                            ptr_ext   <= 1'b1;
                            lock_cnt  <= '0;
                        end
                    end
                end
                ACCESS: begin
                    // WR_o still holds the latched direction of this access
                    WR_o  <= 1'b0;
                    state <= DONE;
                    if (GNT_o[1]) begin
                        EXT_ACK_o <= 1'b1;
                        if (!WR_o) begin
                            EXT_RDATA_o <= OUT_DATA_i;
                        end
                    end else begin
                        CPU_ACK_o <= 1'b1;
                        if (!WR_o) begin
                            CPU_RDATA_o <= OUT_DATA_i;
                        end
                    end
                end
                DONE: begin
                    CPU_ACK_o <= 1'b0;
                    EXT_ACK_o <= 1'b0;
                    GNT_o     <= 2'b00;
                    state     <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dm_arbiter.sv
// Testbench for dm_arbiter: behavioural RAM, transaction-level arbitration/memory
// reference model, directed scenarios and randomized traffic.
module tb_dm_arbiter;
    localparam int AW = 11;
    localparam int DW = 11;
    localparam int ML = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          cpu_req, cpu_wr, cpu_ack;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata, cpu_rdata;
    logic          ext_req, ext_wr, ext_lock, ext_ack;
    logic [AW-1:0] ext_addr;
    logic [DW-1:0] ext_wdata, ext_rdata;
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] in_data, out_data;
    logic [1:0]    gnt;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    always #5 clk = ~clk;

    dm_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_LOCK(ML)) dut (
        .CLK_i(clk), .RST_i(rst_n),
        .CPU_REQ_i(cpu_req), .CPU_WR_i(cpu_wr), .CPU_ADDR_i(cpu_addr), .CPU_WDATA_i(cpu_wdata),
        .CPU_ACK_o(cpu_ack), .CPU_RDATA_o(cpu_rdata),
        .EXT_REQ_i(ext_req), .EXT_WR_i(ext_wr), .EXT_ADDR_i(ext_addr), .EXT_WDATA_i(ext_wdata),
        .EXT_LOCK_i(ext_lock), .EXT_ACK_o(ext_ack), .EXT_RDATA_o(ext_rdata),
        .WR_o(wr), .ADDR_dm_o(addr), .IN_DATA_o(in_data), .OUT_DATA_i(out_data), .GNT_o(gnt)
    );

    // RAM environment: synchronous write, combinational read
    logic [DW-1:0] ram [0:2**AW-1];
    logic          ram_clr = 1'b1;
    always @(posedge clk) begin
        if (ram_clr) begin
            for (int i = 0; i < 2**AW; i++) ram[i] <= '0;
        end else if (wr) begin
            ram[addr] <= in_data;
        end
    end
    assign out_data = ram[addr];

    // Reference model state: memory contents, round-robin owner, lock budget, response regs
    logic [DW-1:0] m_mem [0:2**AW-1];
    bit            m_ptr_ext;
    int            m_cnt;
    logic [DW-1:0] m_cpu_rd, m_ext_rd;
    bit            glog[$];

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic model_reset();
        m_ptr_ext = 1'b0;
        m_cnt     = 0;
        m_cpu_rd  = '0;
        m_ext_rd  = '0;
    endtask

    task automatic model_grant(input bit creq, input bit ereq, input bit lock, output bit win_ext);
        if (creq && ereq) win_ext = m_ptr_ext && (m_cnt < ML);
        else              win_ext = ereq;
        if (win_ext && lock) begin
            m_ptr_ext = 1'b1;
            if (m_cnt < ML) m_cnt++;
        end else if (win_ext) begin
            m_ptr_ext = 1'b0;
            m_cnt     = 0;
        end else begin
            m_ptr_ext = 1'b1;
            m_cnt     = 0;
        end
    endtask

    function automatic logic [AW-1:0] rand_addr();
        case ($urandom_range(0, 3))
            0:       return AW'(2**AW - 1);
            1:       return '0;
            default: return AW'($urandom_range(0, 7));
        endcase
    endfunction

    task automatic new_txn(input bit is_ext);
        if (is_ext) begin
            ext_wr = 1'($urandom_range(0, 1)); ext_addr = rand_addr(); ext_wdata = DW'($urandom);
        end else begin
            cpu_wr = 1'($urandom_range(0, 1)); cpu_addr = rand_addr(); cpu_wdata = DW'($urandom);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0; cpu_req = 1'b0; ext_req = 1'b0; ext_lock = 1'b0;
        tick();
        ram_clr = 1'b0;
        tick();
        n_tests++;
        if ({wr, addr, in_data, gnt, cpu_ack, ext_ack, cpu_rdata, ext_rdata} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: wr=%b addr=%h in=%h gnt=%b acks=%b%b rd=%h/%h, want all zero",
                     wr, addr, in_data, gnt, cpu_ack, ext_ack, cpu_rdata, ext_rdata);
        end
        rst_n = 1'b1;
        model_reset();
    endtask

    // One isolated access with cycle-exact latency checks; DUT assumed idle
    task automatic single_access(input bit is_ext, input bit w, input logic [AW-1:0] a,
                                 input logic [DW-1:0] d);
        bit            win;
        logic [1:0]    exp_g;
        logic [DW-1:0] exp_rd;
        ext_lock = 1'b0;
        if (is_ext) begin ext_req = 1'b1; ext_wr = w; ext_addr = a; ext_wdata = d; end
        else        begin cpu_req = 1'b1; cpu_wr = w; cpu_addr = a; cpu_wdata = d; end
        model_grant(!is_ext, is_ext, 1'b0, win);
        exp_g = win ? 2'b10 : 2'b01;
        tick();
        n_tests++;
        if (gnt !== exp_g || wr !== w || addr !== a || in_data !== d || cpu_ack || ext_ack) begin
            n_fail++;
            $display("FAIL single_access_phase: gnt=%b wr=%b addr=%0d in=%h acks=%b%b, want gnt=%b wr=%b addr=%0d in=%h acks=00",
                     gnt, wr, addr, in_data, cpu_ack, ext_ack, exp_g, w, a, d);
        end
        if (w) m_mem[a] = d;
        else if (is_ext) m_ext_rd = m_mem[a];
        else m_cpu_rd = m_mem[a];
        exp_rd = m_mem[a];
        tick();
        n_tests++;
        if ({cpu_ack, ext_ack} !== {!is_ext, is_ext} || wr !== 1'b0 || gnt !== exp_g) begin
            n_fail++;
            $display("FAIL single_ack: acks=%b%b wr=%b gnt=%b, want acks=%b%b wr=0 gnt=%b",
                     cpu_ack, ext_ack, wr, gnt, !is_ext, is_ext, exp_g);
        end
        n_tests++;
        if (cpu_rdata !== m_cpu_rd || ext_rdata !== m_ext_rd) begin
            n_fail++;
            $display("FAIL single_rdata: cpu=%h ext=%h, want cpu=%h ext=%h (word %h)",
                     cpu_rdata, ext_rdata, m_cpu_rd, m_ext_rd, exp_rd);
        end
        cpu_req = 1'b0; ext_req = 1'b0;
        tick();
        n_tests++;
        if (gnt !== 2'b00 || cpu_ack || ext_ack || wr) begin
            n_fail++;
            $display("FAIL single_release: gnt=%b acks=%b%b wr=%b, want gnt=00 acks=00 wr=0",
                     gnt, cpu_ack, ext_ack, wr);
        end
    endtask

    // Traffic engine. en: 0 = silent, 1 = always requesting, 2 = random requests.
    // lock_mode: 0 = low, 1 = high, 2 = random per cycle.
    task automatic run_traffic(input int n, input int cpu_en, input int ext_en, input int lock_mode);
        bit            c_pend, e_pend, stop, done, win, g_ext, g_wr, drv_c, drv_e, drv_l;
        logic [1:0]    exp_g;
        logic [AW-1:0] g_a;
        logic [DW-1:0] g_d;
        int            phase, grants, last_wr;
        glog.delete();
        c_pend = (cpu_en == 1); e_pend = (ext_en == 1);
        stop = 1'b0; done = 1'b0; phase = 0; grants = 0; last_wr = -10;
        new_txn(1'b0); new_txn(1'b1);
        for (int t = 0; t < n * 12 + 20 && !done; t++) begin
            if (!stop) begin
                if (cpu_en == 2 && !c_pend) c_pend = 1'($urandom_range(0, 1));
                if (ext_en == 2 && !e_pend) e_pend = 1'($urandom_range(0, 1));
            end
            cpu_req  = c_pend;
            ext_req  = e_pend;
            ext_lock = (lock_mode == 2) ? 1'($urandom_range(0, 1)) : (lock_mode == 1);
            drv_c = cpu_req; drv_e = ext_req; drv_l = ext_lock;
            tick();
            if (wr) begin
                n_tests++;
                if (cyc - last_wr < 3) begin
                    n_fail++;
                    $display("FAIL wr_spacing: pulses %0d cycles apart, want >= 3", cyc - last_wr);
                end
                last_wr = cyc;
            end
            case (phase)
                0: begin
                    exp_g = 2'b00;
                    if (drv_c || drv_e) begin
                        model_grant(drv_c, drv_e, drv_l, win);
                        exp_g = win ? 2'b10 : 2'b01;
                    end
                    n_tests++;
                    if (gnt !== exp_g) begin
                        n_fail++;
                        $display("FAIL grant: gnt=%b, want %b (req c=%b e=%b lock=%b)",
                                 gnt, exp_g, drv_c, drv_e, drv_l);
                        done = 1'b1;
                    end else if (exp_g != 2'b00) begin
                        g_ext = win;
                        g_wr  = win ? ext_wr    : cpu_wr;
                        g_a   = win ? ext_addr  : cpu_addr;
                        g_d   = win ? ext_wdata : cpu_wdata;
                        glog.push_back(gnt == 2'b10);
                        n_tests++;
                        if (wr !== g_wr || addr !== g_a || in_data !== g_d) begin
                            n_fail++;
                            $display("FAIL ram_port: wr=%b addr=%0d in=%h, want wr=%b addr=%0d in=%h",
                                     wr, addr, in_data, g_wr, g_a, g_d);
                        end
                        if (g_wr) m_mem[g_a] = g_d;
                        phase = 1;
                    end
                end
                1: begin
                    n_tests++;
                    if ({cpu_ack, ext_ack} !== {!g_ext, g_ext} || wr !== 1'b0) begin
                        n_fail++;
                        $display("FAIL traffic_ack: acks=%b%b wr=%b, want acks=%b%b wr=0",
                                 cpu_ack, ext_ack, wr, !g_ext, g_ext);
                    end
                    if (!g_wr) begin
                        if (g_ext) m_ext_rd = m_mem[g_a];
                        else       m_cpu_rd = m_mem[g_a];
                    end
                    n_tests++;
                    if (cpu_rdata !== m_cpu_rd || ext_rdata !== m_ext_rd) begin
                        n_fail++;
                        $display("FAIL traffic_rdata: cpu=%h ext=%h, want cpu=%h ext=%h",
                                 cpu_rdata, ext_rdata, m_cpu_rd, m_ext_rd);
                    end
                    grants++;
                    if (g_ext) begin e_pend = (ext_en == 1); new_txn(1'b1); end
                    else       begin c_pend = (cpu_en == 1); new_txn(1'b0); end
                    if (grants >= n) begin stop = 1'b1; c_pend = 1'b0; e_pend = 1'b0; end
                    cpu_req = c_pend; ext_req = e_pend;
                    phase = 2;
                end
                default: begin
                    n_tests++;
                    if (gnt !== 2'b00 || cpu_ack || ext_ack) begin
                        n_fail++;
                        $display("FAIL traffic_idle: gnt=%b acks=%b%b, want gnt=00 acks=00",
                                 gnt, cpu_ack, ext_ack);
                    end
                    phase = 0;
                    if (stop) done = 1'b1;
                end
            endcase
        end
        if (!done) begin
            n_tests++; n_fail++;
            $display("FAIL traffic_timeout: %0d of %0d grants completed", grants, n);
        end
        cpu_req = 1'b0; ext_req = 1'b0; ext_lock = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
    endtask

    task automatic test_write_read();
        logic [DW-1:0] cpu_before;
        single_access(1'b0, 1'b1, AW'(5), DW'('h2A7));
        single_access(1'b0, 1'b0, AW'(5), '0);
        n_tests++;
        if (cpu_rdata !== DW'('h2A7)) begin
            n_fail++;
            $display("FAIL cpu_read_back: got %h, want 2a7", cpu_rdata);
        end
        single_access(1'b0, 1'b1, AW'(1023), DW'('h7FF));
        cpu_before = cpu_rdata;
        single_access(1'b1, 1'b0, AW'(1023), '0);
        n_tests++;
        if (ext_rdata !== DW'('h7FF) || cpu_rdata !== cpu_before) begin
            n_fail++;
            $display("FAIL ext_read_back: ext=%h cpu=%h, want ext=7ff cpu=%h", ext_rdata, cpu_rdata, cpu_before);
        end
    endtask

    task automatic test_alternate();
        bit alt;
        run_traffic(8, 1, 1, 0);
        alt = (glog.size() == 8);
        for (int i = 1; i < glog.size(); i++) if (glog[i] == glog[i-1]) alt = 1'b0;
        n_tests++;
        if (!alt) begin
            n_fail++;
            $display("FAIL alternate: %0d grants, alternation=%b, want 8 strictly alternating", glog.size(), alt);
        end
    endtask

    task automatic test_lock();
        bit exp_seq[11];
        bit ok;
        exp_seq = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        do_reset();
        run_traffic(11, 1, 1, 1);
        ok = (glog.size() == 11);
        for (int i = 0; i < glog.size() && i < 11; i++) if (glog[i] != exp_seq[i]) ok = 1'b0;
        n_tests++;
        if (!ok) begin
            n_fail++;
            $display("FAIL lock_sequence: %0d grants, first=%b, want C,E,E,E,E,C,E,E,E,E,C",
                     glog.size(), glog.size() > 0 ? glog[0] : 1'b0);
        end
    endtask

    task automatic test_random();
        run_traffic(30, 2, 2, 2);
        run_traffic(10, 1, 0, 2);
        run_traffic(10, 0, 1, 1);
        run_traffic(6, 1, 1, 1);
        run_traffic(20, 2, 1, 2);
    endtask

    task automatic test_reset_mid_access();
        ext_lock = 1'b0;
        ext_req = 1'b1; ext_wr = 1'b1; ext_addr = AW'(1023); ext_wdata = DW'('h7FF);
        tick();
        n_tests++;
        if (gnt !== 2'b10 || wr !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_reset_setup: gnt=%b wr=%b, want gnt=10 wr=1", gnt, wr);
        end
        rst_n = 1'b0;
        tick();
        n_tests++;
        if (wr !== 1'b0 || gnt !== 2'b00 || ext_ack !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_reset_abort: wr=%b gnt=%b ext_ack=%b, want 0/00/0", wr, gnt, ext_ack);
        end
        ext_req = 1'b0;
        rst_n = 1'b1;
        tick();
        n_tests++;
        if (ext_ack !== 1'b0 || gnt !== 2'b00) begin
            n_fail++;
            $display("FAIL mid_reset_no_ack: ext_ack=%b gnt=%b, want 0/00", ext_ack, gnt);
        end
        model_reset();
        run_traffic(4, 1, 1, 0);
        n_tests++;
        if (glog.size() == 0 || glog[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL post_reset_winner: %0d grants, first_ext=%b, want first grant CPU",
                     glog.size(), glog.size() > 0 ? glog[0] : 1'b1);
        end
    endtask

    initial begin
        rst_n = 1'b0; cpu_req = 1'b0; cpu_wr = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        ext_req = 1'b0; ext_wr = 1'b0; ext_addr = '0; ext_wdata = '0; ext_lock = 1'b0;
        for (int i = 0; i < 2**AW; i++) m_mem[i] = '0;
        model_reset();
        test_reset();
        test_write_read();
        test_alternate();
        test_lock();
        test_random();
        test_reset_mid_access();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/dm_arbiter.md
Name: dm_arbiter

Overview:
Two-port arbiter that shares the single data-memory RAM between the BIP-2 CPU datapath and an external loader/debug port (EXT).
It serialises accesses through a request/acknowledge handshake and registers the RAM address, write data and write strobe for each access.
It captures the RAM's combinational read data into a per-requester response register.
Grants alternate round-robin; EXT may lock for bounded bursts.

Parameters:
ADDR_WIDTH, 11, width of data-memory address (matches RAM address port)
DATA_WIDTH, 11, data word width
MAX_LOCK, 4, max consecutive EXT grants under lock while CPU is requesting (1..15)

Ports:
CLK_i  in  1  system clock, all logic on rising edge
RST_i  in  1  synchronous, active-low reset
CPU_REQ_i  in  1  CPU access request, held until CPU_ACK_o
CPU_WR_i  in  1  1 = write, 0 = read
CPU_ADDR_i  in  ADDR_WIDTH  CPU address
CPU_WDATA_i  in  DATA_WIDTH  CPU write data
CPU_ACK_o  out  1  one-cycle completion pulse
CPU_RDATA_o  out  DATA_WIDTH  read data, valid with CPU_ACK_o, held until next CPU read ack
EXT_REQ_i, EXT_WR_i, EXT_ADDR_i, EXT_WDATA_i  in  1/1/ADDR_WIDTH/DATA_WIDTH  same as CPU
EXT_LOCK_i  in  1  EXT requests burst priority
EXT_ACK_o, EXT_RDATA_o  out  1/DATA_WIDTH  same as CPU
WR_o  out  1  RAM write strobe
ADDR_dm_o  out  ADDR_WIDTH  RAM address
IN_DATA_o  out  DATA_WIDTH  RAM write data
OUT_DATA_i  in  DATA_WIDTH  RAM read data (combinational from RAM)
GNT_o  out  2  current owner: 00 none, 01 CPU, 10 EXT

Behaviour:
- Reset (RST_i=0 at an edge): state IDLE; all outputs 0; priority pointer = CPU; lock counter = 0.
- Reset mid-access: WR_o=0 from the next edge, no ACK issued, and the access is abandoned.
- FSM states:
  - IDLE: at an edge with any REQ high, choose a winner. Latch its WR/ADDR/WDATA into WR_o/ADDR_dm_o/IN_DATA_o, set GNT_o, go to ACCESS. With no request, stay in IDLE; WR_o=0 and GNT_o=00.
  - ACCESS (exactly 1 cycle): RAM outputs stable. WR_o=1 only if the latched access is a write. At the exiting edge, capture OUT_DATA_i into the winner's RDATA register (reads only; writes leave RDATA unchanged). Drop WR_o to 0, assert the winner's ACK, go to DONE.
  - DONE (1 cycle): winner's ACK=1, GNT_o held; the requester drops REQ. Unconditionally go to IDLE; ACK returns to 0 and GNT_o to 00.
- Latency: REQ sampled at edge k, ACCESS during cycle k+1, ACK high during cycle k+2. Peak throughput is one access per 3 cycles.
- ADDR_dm_o/IN_DATA_o keep their last values while idle; only WR_o gates writes.
- Arbitration with both REQ high in IDLE:
  - Winner = requester named by the priority pointer.
  - Pointer flips to the other requester after every grant, except under EXT lock.
- Lock rule:
  - If EXT is granted while EXT_LOCK_i=1, the lock counter increments and the pointer stays EXT.
  - Once the counter reaches MAX_LOCK, the next arbitration with CPU_REQ_i=1 grants CPU.
  - The counter clears on any CPU grant or when EXT is granted with EXT_LOCK_i=0.
  - With CPU idle, EXT is granted regardless of the counter; the counter saturates at MAX_LOCK.
- A single requester is always granted immediately, whatever the pointer.
- REQ deassertion before ACK is a protocol violation. If a REQ drops while in ACCESS/DONE, the access still completes and ACK still pulses.
- Widths: addresses/data pass unmodified; no arithmetic on data paths.

Test Plan:
- Reset then CPU write addr 5 data 0x2A7 -> WR_o=1 for exactly one cycle with ADDR_dm_o=5 and IN_DATA_o=0x2A7; CPU_ACK_o pulses 2 cycles after REQ is sampled.
- CPU read addr 5 after that write -> CPU_RDATA_o=0x2A7 coincident with CPU_ACK_o; WR_o stays 0 throughout.
- CPU and EXT both requesting continuously, lock low -> grants alternate CPU, EXT, CPU, EXT; GNT_o sequence 01,10,01,10; no two WR_o pulses closer than 3 cycles.
- EXT_LOCK_i=1, MAX_LOCK=4, both requesting -> EXT granted 4 times consecutively, then CPU; counter is 0 after the CPU grant.
- EXT read of a word written earlier by CPU (addr 1023, data 0x7FF) -> EXT_RDATA_o=0x7FF; CPU_RDATA_o unchanged.
- RST_i driven low during ACCESS of an EXT write -> WR_o=0, GNT_o=00, no EXT_ACK_o; after release, a CPU request wins first.
